mem_port_arbiter: RTL

Shares one single-port synchronous RAM between the CPU instruction-fetch path (read-only) and the data path that reads and writes the M register. Sits between the fetch/control logic and the RAM macro. Arbitrates requests (round-robin or fixed data priority), issues one RAM access at a time, counts RAM read latency and returns read data with a one-cycle valid pulse.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_arbiter_2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states and requester IDs.
// Values match the legacy include file so existing decode logic still lines up.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Two-way arbiter between fetch and data requesters; owns last_grant.
// Round-robin on ties, or data always wins ties when DATA_PRIO is set.
module rr_arbiter_2
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_PRIO = 0
)(
   input  logic clk,
   input  logic rst,
   input  logic i_req_f,
   input  logic i_req_d,
   input  logic i_advance,
   output logic o_grant_valid,
   output logic o_grant_id
);

   logic r_last_grant;

   always_comb begin
      o_grant_valid = i_req_f | i_req_d;
      if (i_req_f && i_req_d) begin
         o_grant_id = (DATA_PRIO != 0) ? PORT_DATA : ~r_last_grant;
      end else begin
         o_grant_id = i_req_d ? PORT_DATA : PORT_FETCH;
      end
   end

   // Reset to data so that fetch wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= PORT_DATA;
      end else if (i_advance && o_grant_valid) begin
         r_last_grant <= o_grant_id;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the data path.
// One access at a time: IDLE -> ISSUE -> (write: IDLE | read: WAIT -> RESP -> IDLE).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1,
   parameter int DATA_PRIO    = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_rvalid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
      $error("mem_port_arbiter: READ_LATENCY=%0d is outside 1..7", READ_LATENCY);
   end

   logic [1:0] r_state;
   logic       r_winner;
   logic       r_is_write;
   logic [2:0] r_count;
   logic       w_advance;
   logic       w_grant_valid;
   logic       w_grant_id;

   assign w_advance = (r_state == ST_IDLE);

   rr_arbiter_2 #(.DATA_PRIO(DATA_PRIO)) u_arb (
      .clk           (clk),
      .rst           (rst),
      .i_req_f       (f_req),
      .i_req_d       (d_req),
      .i_advance     (w_advance),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_winner   <= PORT_FETCH;
         r_is_write <= 1'b0;
         r_count    <= '0;
         f_ack      <= 1'b0;
         d_ack      <= 1'b0;
         f_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         f_rdata    <= '0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         f_ack    <= 1'b0;
         d_ack    <= 1'b0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Winner's request fields are captured straight into the RAM outputs.
               if (w_grant_valid) begin
                  r_state  <= ST_ISSUE;
                  r_winner <= w_grant_id;
                  busy     <= 1'b1;
                  mem_en   <= 1'b1;
                  if (w_grant_id == PORT_DATA) begin
                     d_ack      <= 1'b1;
                     mem_addr   <= d_addr;
                     mem_we     <= d_we;
                     mem_wdata  <= d_wdata;
                     r_is_write <= d_we;
                  end else begin
                     f_ack      <= 1'b1;
                     mem_addr   <= f_addr;
                     r_is_write <= 1'b0;
                  end
               end
            end
            ST_ISSUE: begin
               if (r_is_write) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  r_state <= ST_WAIT;
                  r_count <= LAT_LOAD;
               end
            end
            ST_WAIT: begin
               if (r_count == '0) begin
                  r_state <= ST_RESP;
                  if (r_winner == PORT_DATA) begin
                     d_rdata  <= mem_rdata;
                     d_rvalid <= 1'b1;
                  end else begin
                     f_rdata  <= mem_rdata;
                     f_rvalid <= 1'b1;
                  end
               end else begin
                  r_count <= r_count - 3'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
